// File: rtl/sig_stim_gen.sv
// Stimulus source for the start/stop/data window protocol: drives one framed window of
// PRBS or pattern bits per go request and computes the signature an analyzer must latch.
module sig_stim_gen #(
  parameter int LEN_W      = 16,
  parameter int ARM_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             go,
  input  logic [LEN_W-1:0] len,
  input  logic             mode,
  input  logic [15:0]      seed,
  output logic             busy,
  output logic             start,
  output logic             stop,
  output logic             data,
  output logic             done,
  output logic [15:0]      expected_sig
);

  localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_START = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             mode_q, mode_d;
  logic [15:0]      src_q, src_d;
  logic [15:0]      sig_q, sig_d;
  logic [15:0]      exp_q, exp_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic             stop_q, stop_d;
  logic             data_q, data_d;
  logic             done_q, done_d;
  logic             accept;
  logic             src_fb;

  assign accept = (state_q == S_IDLE) && go && (len != '0);

  // State register
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_ARM;
      S_ARM:   if (arm_cnt_q == ARM_LAST) state_d = S_START;
      S_START: state_d = S_SHIFT;
      S_SHIFT: if (bit_cnt_q == LEN_W'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pattern mode rotates the word; PRBS mode is x^16+x^14+x^13+x^11+1 Fibonacci feedback.
  assign src_fb = mode_q ? src_q[15] : (src_q[15] ^ src_q[13] ^ src_q[12] ^ src_q[10]);

  // Datapath next-state: counters, bit source and signature
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    arm_cnt_d = '0;
    bit_cnt_d = bit_cnt_q;
    mode_d    = mode_q;
    src_d     = src_q;
    sig_d     = sig_q;
    exp_d     = exp_q;
    if (state_q == S_ARM) arm_cnt_d = arm_cnt_q + ARM_W'(1);
    if (accept) begin
      bit_cnt_d = len;
      mode_d    = mode;
      src_d     = seed;
    end
    if (state_q == S_SHIFT) bit_cnt_d = bit_cnt_q - LEN_W'(1);
    if (state_d == S_SHIFT) src_d = {src_q[14:0], src_fb};
    if (state_q == S_START) sig_d = '0;
    if (state_q == S_SHIFT)
      sig_d = {sig_q[14:0], data_q ^ sig_q[6] ^ sig_q[8] ^ sig_q[11] ^ sig_q[15]};
    if (state_d == S_DONE) exp_d = sig_d;
  end

  // Output logic: decoded from the upcoming state so the registered pins line up with it
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    start_d = (state_d == S_START);
    stop_d  = (state_d == S_SHIFT) && (bit_cnt_d == LEN_W'(1));
    data_d  = (state_d == S_SHIFT) && src_q[15];
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      arm_cnt_q <= '0;
      bit_cnt_q <= '0;
      mode_q    <= 1'b0;
      src_q     <= '0;
      sig_q     <= '0;
      exp_q     <= '0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      data_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      mode_q    <= mode_d;
      src_q     <= src_d;
      sig_q     <= sig_d;
      exp_q     <= exp_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  assign busy         = busy_q;
  assign start        = start_q;
  assign stop         = stop_q;
  assign data         = data_q;
  assign done         = done_q;
  assign expected_sig = exp_q;

endmodule
